qeciphy_tx_boundary_sched: RTL and testbench
============================================

// Module: qeciphy_tx_boundary_sched
// PURPOSE
//  Free-running frame scheduler and TX link-state controller for the TX packet generator.
//  Generates the FAW/CRC boundary strobes that carve the 64-bit TX word stream into superframes:
//  one FAW word followed by FAW_INTERVAL CRC groups, each group being 6 data slots + 1 validation slot.
//  Owns the OFF/IDLE/ACTIVE state that gates boundary-character and user-data insertion.
//  State changes are aligned to superframe starts; only the drop to OFF is immediate.
// PARAMETERS
//  FAW_INTERVAL   64  CRC groups per superframe; legal 2..1024; superframe = 1 + 7*FAW_INTERVAL cycles
//  FAW_BURST_LEN  16  short superframes emitted after leaving OFF (QECIPHY_TX_FAW_BURST_EN only); legal 1..255
// PORTS
//  clk_i           in   1  TX word clock
//  rst_i           in   1  asynchronous active-high reset
//  enable_i        in   1  link enabled by link controller; low forces OFF
//  active_req_i    in   1  local request to carry user data
//  remote_rdy_i    in   1  far-end receiver ready (from RX FAW rx_rdy)
//  faw_boundary_o  out  1  current slot is a FAW slot
//  crc_boundary_o  out  1  current slot is a validation-word slot
//  tx_off_o        out  1  state OFF
//  tx_idle_o       out  1  state IDLE
//  tx_active_o     out  1  state ACTIVE
//  sf_count_o      out  16 superframe counter, wraps at 0xFFFF
//  faw_burst_o     out  1  short-superframe burst in progress
// BEHAVIOUR
//  Reset: all outputs 0 except tx_off_o=1; word_cnt=0, group_cnt=0, burst_cnt=0.
//  First cycle after rst_i deasserts is slot p=0 (FAW).
//  Slot position:
//   - p=0: faw_boundary_o=1.
//   - p>=1: word_cnt=(p-1)%7; crc_boundary_o=1 when word_cnt==6.
//   - All outputs registered.
//   - Both strobes are never high together; strobes free-run in every state.
//  Counters:
//   - word_cnt: 3 bits, 0..6.
//   - group_cnt: $clog2(FAW_INTERVAL) bits.
//   - At word_cnt==6 and group_cnt==FAW_INTERVAL-1, the next slot is p=0 and both counters clear.
//  sf_count_o increments (mod 2^16) in each p=0 cycle.
//  Superframe commit point (sf_last): the edge at the end of the last CRC slot.
//   - A state change evaluated at sf_last is visible in the same cycle as the following faw_boundary_o.
//  FSM, one-hot outputs, transitions in priority order:
//   - any state: enable_i==0 -> OFF on the next edge (immediate, mid-superframe allowed).
//   - OFF -> IDLE at sf_last if enable_i.
//   - IDLE -> ACTIVE at sf_last if active_req_i && remote_rdy_i.
//   - ACTIVE -> IDLE at sf_last if !active_req_i || !remote_rdy_i.
//  Inputs are sampled only at sf_last, except enable_i. Toggles between commit points are ignored.
//  Reset mid-operation: asynchronous clear to the reset values above.
//  The slot position restarts at p=0 after release.
// CONFIGURATION
//  Macro QECIPHY_TX_FAW_BURST_EN.
//  Defined:
//   - On the OFF->IDLE commit, burst_cnt loads FAW_BURST_LEN.
//   - While burst_cnt!=0, superframes are 1 group long: 8 cycles, FAW at p=0, CRC at p=7.
//   - burst_cnt decrements at each short sf_last.
//   - faw_burst_o=1 while burst_cnt!=0.
//   - IDLE->ACTIVE is blocked until burst_cnt==0.
//   - Entering OFF clears burst_cnt.
//  Undefined:
//   - faw_burst_o tied 0 and FAW_BURST_LEN unused.
//   - Superframe length is always 1 + 7*FAW_INTERVAL.
// STRUCTURE
//  Shared package:
//   - typedef enum logic [1:0] qeciphy_tx_state_t {TX_OFF, TX_IDLE, TX_ACTIVE}.
//   - localparam QECIPHY_DATA_SLOTS_PER_GROUP = 6.
//   - localparam QECIPHY_GROUP_LEN = 7.
//  Sub-module qeciphy_sf_counter:
//   - Contains the word/group/burst counters.
//   - Outputs faw/crc strobes and sf_last.
//  Top level holds the FSM and output decode.
// TESTING (FAW_INTERVAL=4, FAW_BURST_LEN=2)
//  1. Reset release, enable_i=0 for 60 cycles:
//     - faw at p=0, 29, 58; crc at p=7, 14, 21, 28.
//     - tx_off_o=1 throughout; sf_count_o=3 after p=58.
//  2. enable_i=1 at p=10:
//     - tx_idle_o rises with the FAW at p=29, not before.
//     - Burst build: 2 superframes of 8 cycles, faw_burst_o=1 for 16 cycles, then 29-cycle superframes.
//  3. IDLE, then active_req_i=1, remote_rdy_i=1:
//     - tx_active_o rises exactly at the next FAW cycle.
//     - Dropping remote_rdy_i mid-superframe returns IDLE at the following FAW only.
//  4. ACTIVE, enable_i=0 at p=12:
//     - tx_off_o=1 at p=13; strobes continue unchanged.
//  5. rst_i pulsed for 1 cycle at p=17:
//     - Outputs cleared asynchronously; first post-reset cycle has faw_boundary_o=1.
//  6. Assertions (all runs):
//     - !(faw_boundary_o && crc_boundary_o).
//     - $onehot({tx_off_o, tx_idle_o, tx_active_o}).
//     - sf_count_o wrap from 0xFFFF to 0 via forced counter.

Source files
------------

// File: rtl/qeciphy_tx_boundary_sched_pkg.sv
// Shared types and slot geometry for the TX boundary scheduler (optional QECIPHY_TX_FAW_BURST_EN build).
// Constants only; no latency, no backpressure.
package qeciphy_tx_boundary_sched_pkg;

  typedef enum logic [1:0] {
    TX_OFF,
    TX_IDLE,
    TX_ACTIVE
  } qeciphy_tx_state_t;

  localparam int QECIPHY_DATA_SLOTS_PER_GROUP = 6;
  localparam int QECIPHY_GROUP_LEN            = 7;
  localparam int QECIPHY_SF_COUNT_W           = 16;

endpackage

// File: rtl/qeciphy_tx_boundary_sched_sf_counter.sv
// Free-running word/group/burst counters producing registered FAW/CRC strobes and sf_last (QECIPHY_TX_FAW_BURST_EN adds short superframes).
// Strobes are registered, one slot per clock; free-running, no backpressure.
module qeciphy_sf_counter
  import qeciphy_tx_boundary_sched_pkg::*;
#(
  parameter int FAW_INTERVAL  = 64,
  parameter int FAW_BURST_LEN = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          burst_load,
  input  logic                          burst_clr,
  output logic                          faw,
  output logic                          crc,
  output logic                          sf_last,
  output logic                          burst,
  output logic [QECIPHY_SF_COUNT_W-1:0] sf_count
);

  localparam int GW = $clog2(FAW_INTERVAL);
  localparam logic [GW-1:0] LAST_GROUP   = GW'(FAW_INTERVAL - 1);
  localparam logic [2:0]    LAST_WORD    = 3'(QECIPHY_GROUP_LEN - 1);
  localparam logic [2:0]    PRE_CRC_WORD = 3'(QECIPHY_DATA_SLOTS_PER_GROUP - 1);

  // restart marks the first edge after reset so that slot p=0 follows release
  logic          restart;
  logic [2:0]    word_cnt;
  logic [GW-1:0] group_cnt;
  logic          short_sf;

  assign sf_last = crc && (short_sf || (group_cnt == LAST_GROUP));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      restart   <= 1'b1;
      faw       <= 1'b0;
      crc       <= 1'b0;
      word_cnt  <= '0;
      group_cnt <= '0;
      sf_count  <= '0;
    end else if (restart || sf_last) begin
      restart   <= 1'b0;
      faw       <= 1'b1;
      crc       <= 1'b0;
      word_cnt  <= '0;
      group_cnt <= '0;
      sf_count  <= sf_count + 16'd1;
    end else if (faw) begin
      faw       <= 1'b0;
      crc       <= 1'b0;
      word_cnt  <= '0;
    end else if (word_cnt == LAST_WORD) begin
      word_cnt  <= '0;
      group_cnt <= group_cnt + GW'(1);
      crc       <= 1'b0;
    end else begin
      word_cnt  <= word_cnt + 3'd1;
      crc       <= (word_cnt == PRE_CRC_WORD);
    end
  end

`ifdef QECIPHY_TX_FAW_BURST_EN
  logic [7:0] burst_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_cnt <= '0;
    end else if (burst_clr) begin
      burst_cnt <= '0;
    end else if (burst_load) begin
      burst_cnt <= 8'(FAW_BURST_LEN);
    end else if (sf_last && (burst_cnt != 8'd0)) begin
      burst_cnt <= burst_cnt - 8'd1;
    end
  end

  assign short_sf = (burst_cnt != 8'd0);
  assign burst    = short_sf;
`else
  logic unused_burst;
  assign unused_burst = burst_load ^ burst_clr ^ (FAW_BURST_LEN == 0);
  assign short_sf     = 1'b0;
  assign burst        = 1'b0;
`endif

endmodule

// File: rtl/qeciphy_tx_boundary_sched.sv
// TX frame scheduler and OFF/IDLE/ACTIVE link state; burst of short superframes under QECIPHY_TX_FAW_BURST_EN.
// All outputs registered; state commits at superframe ends except the immediate drop to OFF; no backpressure.
module qeciphy_tx_boundary_sched
  import qeciphy_tx_boundary_sched_pkg::*;
#(
  parameter int FAW_INTERVAL  = 64,
  parameter int FAW_BURST_LEN = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        active_req_i,
  input  logic        remote_rdy_i,
  output logic        faw_boundary_o,
  output logic        crc_boundary_o,
  output logic        tx_off_o,
  output logic        tx_idle_o,
  output logic        tx_active_o,
  output logic [15:0] sf_count_o,
  output logic        faw_burst_o
);

  qeciphy_tx_state_t state, state_nxt;
  logic              sf_last;
  logic              burst_load;

  qeciphy_sf_counter #(
    .FAW_INTERVAL (FAW_INTERVAL),
    .FAW_BURST_LEN(FAW_BURST_LEN)
  ) u_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .burst_load(burst_load),
    .burst_clr (!enable_i),
    .faw       (faw_boundary_o),
    .crc       (crc_boundary_o),
    .sf_last   (sf_last),
    .burst     (faw_burst_o),
    .sf_count  (sf_count_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= TX_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // faw_burst_o low doubles as "burst finished" for the ACTIVE gate
  always_comb begin
    state_nxt  = state;
    burst_load = 1'b0;
    if (!enable_i) begin
      state_nxt = TX_OFF;
    end else if (sf_last) begin
      case (state)
        TX_OFF: begin
          state_nxt  = TX_IDLE;
          burst_load = 1'b1;
        end
        TX_IDLE: begin
          if (active_req_i && remote_rdy_i && !faw_burst_o) state_nxt = TX_ACTIVE;
        end
        TX_ACTIVE: begin
          if (!active_req_i || !remote_rdy_i) state_nxt = TX_IDLE;
        end
        default: state_nxt = TX_OFF;
      endcase
    end
  end

  assign tx_off_o    = (state == TX_OFF);
  assign tx_idle_o   = (state == TX_IDLE);
  assign tx_active_o = (state == TX_ACTIVE);

endmodule

// File: tb/tb_qeciphy_tx_boundary_sched.sv
// Directed bench for qeciphy_tx_boundary_sched with FAW_INTERVAL=4, FAW_BURST_LEN=2.
// Per-superframe vector table plus hand sequences for immediate OFF, mid-frame reset and counter wrap.
module tb_qeciphy_tx_boundary_sched;

  localparam int FI        = 4;
  localparam int BL        = 2;
  localparam int SF_LEN    = 1 + 7 * FI;
  localparam int SHORT_LEN = 8;
`ifdef QECIPHY_TX_FAW_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  localparam logic [2:0] S_OFF  = 3'b100;
  localparam logic [2:0] S_IDLE = 3'b010;
  localparam logic [2:0] S_ACT  = 3'b001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, areq = 1'b0, rrdy = 1'b0;
  logic        faw, crc, off, idle, act, fburst;
  logic [15:0] sfc;

  qeciphy_tx_boundary_sched #(
    .FAW_INTERVAL (FI),
    .FAW_BURST_LEN(BL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (en),
    .active_req_i  (areq),
    .remote_rdy_i  (rrdy),
    .faw_boundary_o(faw),
    .crc_boundary_o(crc),
    .tx_off_o      (off),
    .tx_idle_o     (idle),
    .tx_active_o   (act),
    .sf_count_o    (sfc),
    .faw_burst_o   (fburst)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [2:0]  st_exp    = S_OFF;
  logic        burst_exp = 1'b0;
  logic [15:0] sf_exp    = 16'd0;

  // inputs applied during superframe k, expected state/burst during superframe k+1
  typedef struct {
    logic       en;
    logic       areq;
    logic       rrdy;
    logic       glitch;
    logic [2:0] st;
    logic       burst;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_slot(input int p);
    check("faw", 32'(faw), 32'(p == 0));
    check("crc", 32'(crc), 32'((p > 0) && (((p - 1) % 7) == 6)));
    check("state", 32'({off, idle, act}), 32'(st_exp));
    check("faw_burst", 32'(fburst), 32'(burst_exp));
    check("sf_count", 32'(sfc), 32'(sf_exp));
  endtask

  task automatic check_reset();
    check("rst_faw", 32'(faw), 32'd0);
    check("rst_crc", 32'(crc), 32'd0);
    check("rst_state", 32'({off, idle, act}), 32'(S_OFF));
    check("rst_sf_count", 32'(sfc), 32'd0);
    check("rst_faw_burst", 32'(fburst), 32'd0);
  endtask

  task automatic run_vec(input int k);
    int len;
    int drv;
    len    = (BURST_ON && burst_exp) ? SHORT_LEN : SF_LEN;
    drv    = (len == SHORT_LEN) ? 2 : 10;
    sf_exp = sf_exp + 16'd1;
    for (int p = 0; p < len; p++) begin
      check_slot(p);
      if (vecs[k].glitch && p == 1) begin
        areq = ~vecs[k].areq;
        rrdy = ~vecs[k].rrdy;
      end
      if (p == drv) begin
        en   = vecs[k].en;
        areq = vecs[k].areq;
        rrdy = vecs[k].rrdy;
      end
      next_cycle();
    end
    st_exp    = vecs[k].st;
    burst_exp = BURST_ON & vecs[k].burst;
  endtask

  always @(negedge clk) begin
    check("strobe_excl", 32'(faw && crc), 32'd0);
    check("state_onehot", 32'($onehot({off, idle, act})), 32'd1);
  end

  initial begin
    // fields: en, areq, rrdy, glitch, next state, next burst (burst build)
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, S_OFF,  1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, S_OFF,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, S_IDLE, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_IDLE, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, S_ACT,  1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, S_ACT,  1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_IDLE, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, S_ACT,  1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, S_ACT,  1'b0};

    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    next_cycle();

    for (int k = 0; k < 12; k++) run_vec(k);

    // enable drops at p=12 of an ACTIVE superframe: OFF from p=13, strobes unaffected
    sf_exp = sf_exp + 16'd1;
    for (int p = 0; p < SF_LEN; p++) begin
      if (p == 13) st_exp = S_OFF;
      check_slot(p);
      if (p == 12) en = 1'b0;
      next_cycle();
    end

    // one-cycle reset pulse at p=17; outputs must clear before any clock edge
    sf_exp = sf_exp + 16'd1;
    for (int p = 0; p < 17; p++) begin
      check_slot(p);
      next_cycle();
    end
    check_slot(17);
    rst = 1'b1;
    #1;
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    sf_exp    = 16'd0;
    st_exp    = S_OFF;
    burst_exp = 1'b0;

    // force the superframe counter to 0xFFFF on the last slot, expect wrap to 0
    sf_exp = sf_exp + 16'd1;
    for (int p = 0; p < SF_LEN; p++) begin
      check_slot(p);
      if (p == SF_LEN - 1) begin
        force dut.u_cnt.sf_count = 16'hFFFF;
        #1;
        check("forced_sf_count", 32'(sfc), 32'h0000_FFFF);
        release dut.u_cnt.sf_count;
        sf_exp = 16'hFFFF;
      end
      next_cycle();
    end
    sf_exp = sf_exp + 16'd1;
    check("sf_count_wrap", 32'(sfc), 32'd0);
    for (int p = 0; p < SF_LEN; p++) begin
      check_slot(p);
      next_cycle();
    end

    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
